// File: rtl/cnn_layer_accel_job_ctrl.sv
// Host-side job sequencer for one cnn_layer_accel quad: issues a job, streams the
// commanded pixel/weight word counts, drains results to a sink and closes the job.
module cnn_layer_accel_job_ctrl #(
    parameter int C_CNT_W  = 20,
    parameter int C_DATA_W = 128,
    parameter int C_RES_W  = 16
) (
    input  logic                clk_if,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [C_DATA_W-1:0] cmd_parameters,
    input  logic [C_CNT_W-1:0]  cmd_num_pixel_words,
    input  logic [C_CNT_W-1:0]  cmd_num_weight_words,
    input  logic [C_CNT_W-1:0]  cmd_num_results,
    output logic                job_start,
    input  logic                job_accept,
    output logic [C_DATA_W-1:0] job_parameters,
    input  logic                job_fetch_request,
    output logic                job_fetch_ack,
    output logic                job_fetch_complete,
    input  logic                job_complete,
    output logic                job_complete_ack,
    input  logic                pix_src_valid,
    output logic                pix_src_ready,
    input  logic [C_DATA_W-1:0] pix_src_data,
    input  logic                wgt_src_valid,
    output logic                wgt_src_ready,
    input  logic [C_DATA_W-1:0] wgt_src_data,
    output logic                pixel_valid,
    input  logic                pixel_ready,
    output logic [C_DATA_W-1:0] pixel_data,
    output logic                weight_valid,
    input  logic                weight_ready,
    output logic [C_DATA_W-1:0] weight_data,
    input  logic                result_valid,
    output logic                result_accept,
    input  logic [C_RES_W-1:0]  result_data,
    output logic                res_sink_valid,
    input  logic                res_sink_ready,
    output logic [C_RES_W-1:0]  res_sink_data,
    output logic                job_done,
    output logic                result_overflow
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_WAIT_FETCH = 3'd2,
        ST_STREAM     = 3'd3,
        ST_RUN        = 3'd4,
        ST_CMPL_ACK   = 3'd5
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [C_CNT_W-1:0]  pix_cnt_r;
    logic [C_CNT_W-1:0]  wgt_cnt_r;
    logic [C_CNT_W-1:0]  res_cnt_r;
    logic [C_CNT_W-1:0]  lat_pix_r;
    logic [C_CNT_W-1:0]  lat_wgt_r;
    logic [C_DATA_W-1:0] param_r;

    logic cmd_ready_r;
    logic job_start_r;
    logic fetch_ack_r;
    logic fetch_complete_r;
    logic cmpl_ack_r;
    logic job_done_r;
    logic overflow_r;

    logic pix_live_s;
    logic wgt_live_s;
    logic res_open_s;
    logic pix_xfer_s;
    logic wgt_xfer_s;
    logic res_xfer_s;
    logic cmd_take_s;
    logic reload_s;
    logic pix_zero_s;
    logic wgt_zero_s;
    logic res_zero_s;

    assign pix_zero_s = (pix_cnt_r == {C_CNT_W{1'b0}});
    assign wgt_zero_s = (wgt_cnt_r == {C_CNT_W{1'b0}});
    assign res_zero_s = (res_cnt_r == {C_CNT_W{1'b0}});

    // Streams only open in STREAM and only while words remain for that stream
    assign pix_live_s = (state_r == ST_STREAM) & ~pix_zero_s;
    assign wgt_live_s = (state_r == ST_STREAM) & ~wgt_zero_s;
    assign res_open_s = (state_r != ST_IDLE);

    assign pixel_valid   = pix_src_valid & pix_live_s;
    assign pix_src_ready = pixel_ready & pix_live_s;
    assign pixel_data    = pix_src_data;
    assign weight_valid  = wgt_src_valid & wgt_live_s;
    assign wgt_src_ready = weight_ready & wgt_live_s;
    assign weight_data   = wgt_src_data;

    assign res_sink_valid = result_valid & res_open_s;
    assign result_accept  = res_sink_ready & res_open_s;
    assign res_sink_data  = result_data;

    assign pix_xfer_s = pix_src_valid & pixel_ready & pix_live_s;
    assign wgt_xfer_s = wgt_src_valid & weight_ready & wgt_live_s;
    assign res_xfer_s = result_valid & res_sink_ready & res_open_s;
    assign cmd_take_s = (state_r == ST_IDLE) & cmd_valid;
    assign reload_s   = (state_r == ST_RUN) & (state_next_s == ST_WAIT_FETCH);

    assign cmd_ready          = cmd_ready_r;
    assign job_start          = job_start_r;
    assign job_parameters     = param_r;
    assign job_fetch_ack      = fetch_ack_r;
    assign job_fetch_complete = fetch_complete_r;
    assign job_complete_ack   = cmpl_ack_r;
    assign job_done           = job_done_r;
    assign result_overflow    = overflow_r;

    // State register
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; completion takes priority over a new fetch pass in RUN
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) state_next_s = ST_START;
                else           state_next_s = ST_IDLE;
            end
            ST_START: begin
                if (job_accept) state_next_s = ST_WAIT_FETCH;
                else            state_next_s = ST_START;
            end
            ST_WAIT_FETCH: begin
                if (job_fetch_request) state_next_s = ST_STREAM;
                else                   state_next_s = ST_WAIT_FETCH;
            end
            ST_STREAM: begin
                if (pix_zero_s && wgt_zero_s) state_next_s = ST_RUN;
                else                          state_next_s = ST_STREAM;
            end
            ST_RUN: begin
                if (job_complete && res_zero_s) state_next_s = ST_CMPL_ACK;
                else if (job_fetch_request)     state_next_s = ST_WAIT_FETCH;
                else                            state_next_s = ST_RUN;
            end
            ST_CMPL_ACK: begin
                if (!job_complete) state_next_s = ST_IDLE;
                else               state_next_s = ST_CMPL_ACK;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Control outputs registered from the upcoming state so they are glitch-free
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            cmd_ready_r      <= 1'b1;
            job_start_r      <= 1'b0;
            fetch_ack_r      <= 1'b0;
            fetch_complete_r <= 1'b0;
            cmpl_ack_r       <= 1'b0;
            job_done_r       <= 1'b0;
        end else begin
            cmd_ready_r      <= (state_next_s == ST_IDLE);
            job_start_r      <= (state_next_s == ST_START);
            fetch_ack_r      <= (state_r == ST_WAIT_FETCH) && (state_next_s == ST_STREAM);
            fetch_complete_r <= (state_r == ST_STREAM) && (state_next_s == ST_RUN);
            cmpl_ack_r       <= (state_next_s == ST_CMPL_ACK);
            job_done_r       <= (state_r == ST_CMPL_ACK) && (state_next_s == ST_IDLE);
        end
    end

    // Command latch: parameters and per-pass word counts kept for multi-pass reloads
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            param_r   <= {C_DATA_W{1'b0}};
            lat_pix_r <= {C_CNT_W{1'b0}};
            lat_wgt_r <= {C_CNT_W{1'b0}};
        end else if (cmd_take_s) begin
            param_r   <= cmd_parameters;
            lat_pix_r <= cmd_num_pixel_words;
            lat_wgt_r <= cmd_num_weight_words;
        end else begin
            param_r   <= param_r;
            lat_pix_r <= lat_pix_r;
            lat_wgt_r <= lat_wgt_r;
        end
    end

    // Pixel/weight remaining counters; a new fetch pass restores the commanded counts
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            pix_cnt_r <= {C_CNT_W{1'b0}};
            wgt_cnt_r <= {C_CNT_W{1'b0}};
        end else if (cmd_take_s) begin
            pix_cnt_r <= cmd_num_pixel_words;
            wgt_cnt_r <= cmd_num_weight_words;
        end else if (reload_s) begin
            pix_cnt_r <= lat_pix_r;
            wgt_cnt_r <= lat_wgt_r;
        end else begin
            pix_cnt_r <= pix_xfer_s ? (pix_cnt_r - {{(C_CNT_W-1){1'b0}}, 1'b1}) : pix_cnt_r;
            wgt_cnt_r <= wgt_xfer_s ? (wgt_cnt_r - {{(C_CNT_W-1){1'b0}}, 1'b1}) : wgt_cnt_r;
        end
    end

    // Result counter spans the whole job (not reloaded per pass); extra results flag overflow
    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            res_cnt_r  <= {C_CNT_W{1'b0}};
            overflow_r <= 1'b0;
        end else if (cmd_take_s) begin
            res_cnt_r  <= cmd_num_results;
            overflow_r <= overflow_r;
        end else if (res_xfer_s && res_zero_s) begin
            res_cnt_r  <= res_cnt_r;
            overflow_r <= 1'b1;
        end else if (res_xfer_s) begin
            res_cnt_r  <= res_cnt_r - {{(C_CNT_W-1){1'b0}}, 1'b1};
            overflow_r <= overflow_r;
        end else begin
            res_cnt_r  <= res_cnt_r;
            overflow_r <= overflow_r;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Scoreboard bench for cnn_layer_accel_job_ctrl: queued expected streams checked by a
// negedge monitor, with a job-level sequence checking handshake timing.
module tb_cnn_layer_accel_job_ctrl;

    localparam int CW = 20;
    localparam int DW = 128;
    localparam int RW = 16;

    logic          clk_if;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [DW-1:0] cmd_parameters;
    logic [CW-1:0] cmd_num_pixel_words;
    logic [CW-1:0] cmd_num_weight_words;
    logic [CW-1:0] cmd_num_results;
    logic          job_start;
    logic          job_accept;
    logic [DW-1:0] job_parameters;
    logic          job_fetch_request;
    logic          job_fetch_ack;
    logic          job_fetch_complete;
    logic          job_complete;
    logic          job_complete_ack;
    logic          pix_src_valid, pix_src_ready;
    logic [DW-1:0] pix_src_data;
    logic          wgt_src_valid, wgt_src_ready;
    logic [DW-1:0] wgt_src_data;
    logic          pixel_valid, pixel_ready;
    logic [DW-1:0] pixel_data;
    logic          weight_valid, weight_ready;
    logic [DW-1:0] weight_data;
    logic          result_valid, result_accept;
    logic [RW-1:0] result_data;
    logic          res_sink_valid, res_sink_ready;
    logic [RW-1:0] res_sink_data;
    logic          job_done;
    logic          result_overflow;

    cnn_layer_accel_job_ctrl #(.C_CNT_W(CW), .C_DATA_W(DW), .C_RES_W(RW)) dut (
        .clk_if(clk_if), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_parameters(cmd_parameters),
        .cmd_num_pixel_words(cmd_num_pixel_words), .cmd_num_weight_words(cmd_num_weight_words),
        .cmd_num_results(cmd_num_results),
        .job_start(job_start), .job_accept(job_accept), .job_parameters(job_parameters),
        .job_fetch_request(job_fetch_request), .job_fetch_ack(job_fetch_ack),
        .job_fetch_complete(job_fetch_complete), .job_complete(job_complete),
        .job_complete_ack(job_complete_ack),
        .pix_src_valid(pix_src_valid), .pix_src_ready(pix_src_ready), .pix_src_data(pix_src_data),
        .wgt_src_valid(wgt_src_valid), .wgt_src_ready(wgt_src_ready), .wgt_src_data(wgt_src_data),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .pixel_data(pixel_data),
        .weight_valid(weight_valid), .weight_ready(weight_ready), .weight_data(weight_data),
        .result_valid(result_valid), .result_accept(result_accept), .result_data(result_data),
        .res_sink_valid(res_sink_valid), .res_sink_ready(res_sink_ready), .res_sink_data(res_sink_data),
        .job_done(job_done), .result_overflow(result_overflow)
    );

    initial clk_if = 1'b0;
    always #5 clk_if = ~clk_if;

    int tests = 0;
    int fails = 0;

    // Source-side data still to offer, and scoreboard queues of expected DUT outputs
    logic [DW-1:0] pix_src_q[$], wgt_src_q[$], pix_exp_q[$], wgt_exp_q[$];
    logic [RW-1:0] res_src_q[$], res_exp_q[$];

    bit pix_pop, wgt_pop, res_pop;
    bit bp;
    bit res_en;
    bit exp_ovf;
    bit ovf_sticky;
    int pix_xfers, wgt_xfers, res_xfers;
    int res_in_job;
    int nr_cur;
    int cyc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string nm, input int act, input int exp);
        tests++;
        fails++;
        $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_if);
        #1;
    endtask

    // Upstream sources, quad and sink models: update just after each rising edge
    initial begin
        pix_src_valid = 0; wgt_src_valid = 0; result_valid = 0;
        pix_src_data = '0; wgt_src_data = '0; result_data = '0;
        pixel_ready = 0; weight_ready = 0; res_sink_ready = 0;
        cyc = 0;
        forever begin
            @(posedge clk_if);
            #2;
            if (pix_pop && pix_src_q.size() > 0) void'(pix_src_q.pop_front());
            if (wgt_pop && wgt_src_q.size() > 0) void'(wgt_src_q.pop_front());
            if (res_pop && res_src_q.size() > 0) void'(res_src_q.pop_front());
            cyc++;
            pix_src_valid  = (pix_src_q.size() > 0) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            pix_src_data   = (pix_src_q.size() > 0) ? pix_src_q[0] : '0;
            wgt_src_valid  = (wgt_src_q.size() > 0) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            wgt_src_data   = (wgt_src_q.size() > 0) ? wgt_src_q[0] : '0;
            pixel_ready    = bp ? ((cyc % 3) == 0) : 1'b1;
            weight_ready   = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            result_valid   = res_en && (res_src_q.size() > 0) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            result_data    = (res_src_q.size() > 0) ? res_src_q[0] : '0;
            res_sink_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: at the falling edge, a valid&ready pair is the transfer of the next rising edge
    initial begin
        logic [DW-1:0] ed;
        logic [RW-1:0] er;
        forever begin
            @(negedge clk_if);
            if (rst) begin
                pix_pop = 0; wgt_pop = 0; res_pop = 0; exp_ovf = 0;
            end else begin
                pix_pop = pix_src_valid & pix_src_ready;
                wgt_pop = wgt_src_valid & wgt_src_ready;
                res_pop = result_valid & result_accept;
                if (pix_pop || (pixel_valid && pixel_ready))
                    chk("pix_src_consume", pix_pop, pixel_valid & pixel_ready);
                if (wgt_pop || (weight_valid && weight_ready))
                    chk("wgt_src_consume", wgt_pop, weight_valid & weight_ready);
                if (res_pop || (res_sink_valid && res_sink_ready))
                    chk("res_forward", res_pop, res_sink_valid & res_sink_ready);
                chk("overflow_flag", result_overflow, exp_ovf);
                if (pixel_valid && pixel_ready) begin
                    pix_xfers++;
                    if (pix_exp_q.size() == 0) note_fail("pix_extra_xfer", pix_xfers, pix_xfers - 1);
                    else begin ed = pix_exp_q.pop_front(); chk("pix_data", pixel_data, ed); end
                end
                if (weight_valid && weight_ready) begin
                    wgt_xfers++;
                    if (wgt_exp_q.size() == 0) note_fail("wgt_extra_xfer", wgt_xfers, wgt_xfers - 1);
                    else begin ed = wgt_exp_q.pop_front(); chk("wgt_data", weight_data, ed); end
                end
                if (res_sink_valid && res_sink_ready) begin
                    res_xfers++;
                    if (res_exp_q.size() == 0) note_fail("res_extra_xfer", res_xfers, res_xfers - 1);
                    else begin er = res_exp_q.pop_front(); chk("res_data", res_sink_data, er); end
                    if (res_in_job >= nr_cur) exp_ovf = 1;
                    res_in_job++;
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        chk({tag, "_job_start"}, job_start, 0);
        chk({tag, "_fetch_ack"}, job_fetch_ack, 0);
        chk({tag, "_fetch_complete"}, job_fetch_complete, 0);
        chk({tag, "_complete_ack"}, job_complete_ack, 0);
        chk({tag, "_job_done"}, job_done, 0);
        chk({tag, "_overflow"}, result_overflow, 0);
        chk({tag, "_parameters"}, job_parameters, 0);
        chk({tag, "_pixel_valid"}, pixel_valid, 0);
        chk({tag, "_weight_valid"}, weight_valid, 0);
        chk({tag, "_pix_src_ready"}, pix_src_ready, 0);
    endtask

    // One complete job as the quad would see it; abort_after>=0 stops inside STREAM
    task automatic run_job(input int np, input int nw, input int nr, input int nsend,
                           input bit early, input bit bpm, input int abort_after);
        logic [DW-1:0] prm, w;
        logic [RW-1:0] r;
        int n;
        bp = bpm;
        pix_src_q.delete(); wgt_src_q.delete(); res_src_q.delete();
        pix_exp_q.delete(); wgt_exp_q.delete(); res_exp_q.delete();
        for (int i = 0; i < np + 3; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            pix_src_q.push_back(w);
            if (i < np) pix_exp_q.push_back(w);
        end
        for (int i = 0; i < nw + 3; i++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            wgt_src_q.push_back(w);
            if (i < nw) wgt_exp_q.push_back(w);
        end
        for (int i = 0; i < nsend; i++) begin
            r = RW'($urandom_range(0, 65535));
            res_src_q.push_back(r);
            res_exp_q.push_back(r);
        end
        pix_xfers = 0; wgt_xfers = 0; res_xfers = 0; res_in_job = 0; nr_cur = nr;
        if (nsend > nr) ovf_sticky = 1;
        prm = {$urandom, $urandom, $urandom, $urandom};

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_parameters = prm;
        cmd_num_pixel_words = CW'(np); cmd_num_weight_words = CW'(nw); cmd_num_results = CW'(nr);
        tick();
        cmd_valid = 0;
        chk("job_start_latency", job_start, 1);
        chk("cmd_ready_busy", cmd_ready, 0);
        chk("job_parameters", job_parameters, prm);
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("job_start_held", job_start, 1);
        end
        job_accept = 1;
        tick();
        job_accept = 0;
        chk("job_start_drop", job_start, 0);
        tick();
        job_fetch_request = 1;
        tick();
        job_fetch_request = 0;
        chk("fetch_ack_on", job_fetch_ack, 1);
        tick();
        chk("fetch_ack_pulse", job_fetch_ack, 0);
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after; i++) tick();
            return;
        end
        n = 0;
        while (!job_fetch_complete && n < 5000) begin tick(); n++; end
        if (n >= 5000) begin note_fail("fetch_complete_timeout", n, 0); return; end
        if (np == 0 && nw == 0) chk("fetch_complete_zero_latency", n, 0);
        chk("pix_all_sent", pix_exp_q.size(), 0);
        chk("wgt_all_sent", wgt_exp_q.size(), 0);
        chk("pix_count", pix_xfers, np);
        chk("wgt_count", wgt_xfers, nw);
        tick();
        chk("fetch_complete_pulse", job_fetch_complete, 0);

        if (early) begin
            job_complete = 1;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("ack_withheld", job_complete_ack, 0);
            end
            res_en = 1;
        end else begin
            res_en = 1;
            n = 0;
            while ((res_exp_q.size() != 0 || res_src_q.size() != 0) && n < 5000) begin tick(); n++; end
            if (n >= 5000) note_fail("result_drain_timeout", res_exp_q.size(), 0);
            job_complete = 1;
        end
        n = 0;
        while (!job_complete_ack && n < 5000) begin tick(); n++; end
        if (n >= 5000) begin note_fail("complete_ack_timeout", n, 0); job_complete = 0; res_en = 0; return; end
        chk("results_before_ack", res_exp_q.size(), 0);
        chk("res_count", res_xfers, nsend);
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("ack_level", job_complete_ack, 1);
        end
        job_complete = 0;
        tick();
        chk("job_done_pulse", job_done, 1);
        chk("cmd_ready_after", cmd_ready, 1);
        chk("ack_released", job_complete_ack, 0);
        tick();
        chk("job_done_single", job_done, 0);
        chk("overflow_end", result_overflow, ovf_sticky);
        res_en = 0;
    endtask

    initial begin
        rst = 1;
        cmd_valid = 0; cmd_parameters = '0;
        cmd_num_pixel_words = '0; cmd_num_weight_words = '0; cmd_num_results = '0;
        job_accept = 0; job_fetch_request = 0; job_complete = 0;
        bp = 0; res_en = 0; ovf_sticky = 0; nr_cur = 0; res_in_job = 0;
        repeat (2) @(posedge clk_if);
        #1;
        check_reset_vals("reset");
        rst = 0;
        tick();

        run_job(400, 9, 324, 324, 0, 0, -1);
        run_job(60, 25, 40, 40, 0, 1, -1);
        run_job(0, 0, 0, 0, 0, 0, -1);
        run_job(8, 3, 5, 5, 1, 1, -1);
        for (int k = 0; k < 3; k++) begin
            int rn;
            rn = $urandom_range(0, 30);
            run_job($urandom_range(0, 40), $urandom_range(0, 20), rn, rn, 0, 1'($urandom_range(0, 1)), -1);
        end
        run_job(4, 4, 10, 11, 0, 0, -1);
        chk("overflow_after_11th", result_overflow, 1);

        run_job(400, 9, 324, 324, 0, 1, 20);
        rst = 1;
        #1;
        check_reset_vals("midstream_reset");
        tick();
        tick();
        pix_src_q.delete(); wgt_src_q.delete(); res_src_q.delete();
        pix_exp_q.delete(); wgt_exp_q.delete(); res_exp_q.delete();
        ovf_sticky = 0; res_en = 0;
        job_accept = 0; job_fetch_request = 0; job_complete = 0;
        rst = 0;
        tick();
        run_job(16, 4, 8, 8, 0, 0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
